sub_pipe_32bit: RTL and testbench

Four-stage pipelined 32-bit subtractor with borrow-in/borrow-out. It is the inverse-direction companion of the team's 32-bit carry-lookahead adder. It computes A − B − Bin one byte per stage, rippling borrow between stages through pipeline registers. A valid/ready handshake with per-stage bubble collapse sustains one result per cycle under backpressure. It sits in the datapath wherever the adder's results must be reversed or compared.

---
 rtl/sub_pipe_32bit_if.sv | 24 ++
 rtl/sub_pipe_32bit.sv | 131 +++++++++++++
 tb/tb_sub_pipe_32bit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sub_pipe_32bit_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
interface sub_pipe_32bit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Diff;
  logic        Bout;
  logic        Ovf;
  logic        Zero;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, Bout, Ovf, Zero
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, Bout, Ovf, Zero
  );
endinterface

// File: rtl/sub_pipe_32bit.sv
// Four-stage byte-serial subtractor, A - B - Bin, with
// valid/ready handshake and per-stage bubble collapse.
module sub_pipe_32bit (
  input logic clk,
  input logic rst,
  sub_pipe_32bit_if.slave bus
);
  logic        r_v1;
  logic        r_c1;
  logic [7:0]  r_d1;
  logic [23:0] r_a1;
  logic [23:0] r_b1;

  logic        r_v2;
  logic        r_c2;
  logic [15:0] r_d2;
  logic [15:0] r_a2;
  logic [15:0] r_b2;

  logic        r_v3;
  logic        r_c3;
  logic [23:0] r_d3;
  logic [7:0]  r_a3;
  logic [7:0]  r_b3;

  logic        r_v4;
  logic [31:0] r_diff;
  logic        r_bout;
  logic        r_ovf;
  logic        r_zero;

  logic        w_adv1;
  logic        w_adv2;
  logic        w_adv3;
  logic        w_adv4;
  logic [8:0]  w_sum1;
  logic [8:0]  w_sum2;
  logic [8:0]  w_sum3;
  logic [8:0]  w_sum4;
  logic [31:0] w_d4;

  assign w_adv4 = !r_v4 || bus.out_ready;
  assign w_adv3 = !r_v3 || w_adv4;
  assign w_adv2 = !r_v2 || w_adv3;
  assign w_adv1 = !r_v1 || w_adv2;

  // Subtraction as A + ~B with the carry chain seeded by ~Bin.
  assign w_sum1 = {1'b0, bus.A[7:0]}
                + {1'b0, ~bus.B[7:0]}
                + {8'd0, ~bus.Bin};
  assign w_sum2 = {1'b0, r_a1[7:0]}
                + {1'b0, ~r_b1[7:0]}
                + {8'd0, r_c1};
  assign w_sum3 = {1'b0, r_a2[7:0]}
                + {1'b0, ~r_b2[7:0]}
                + {8'd0, r_c2};
  assign w_sum4 = {1'b0, r_a3}
                + {1'b0, ~r_b3}
                + {8'd0, r_c3};
  assign w_d4   = {w_sum4[7:0], r_d3};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_c1   <= 1'b0;
      r_d1   <= '0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_v2   <= 1'b0;
      r_c2   <= 1'b0;
      r_d2   <= '0;
      r_a2   <= '0;
      r_b2   <= '0;
      r_v3   <= 1'b0;
      r_c3   <= 1'b0;
      r_d3   <= '0;
      r_a3   <= '0;
      r_b3   <= '0;
      r_v4   <= 1'b0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_v1 <= bus.in_valid;
        if (bus.in_valid) begin
          r_c1 <= w_sum1[8];
          r_d1 <= w_sum1[7:0];
          r_a1 <= bus.A[31:8];
          r_b1 <= bus.B[31:8];
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_c2 <= w_sum2[8];
          r_d2 <= {w_sum2[7:0], r_d1};
          r_a2 <= r_a1[23:8];
          r_b2 <= r_b1[23:8];
        end
      end
      if (w_adv3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_c3 <= w_sum3[8];
          r_d3 <= {w_sum3[7:0], r_d2};
          r_a3 <= r_a2[15:8];
          r_b3 <= r_b2[15:8];
        end
      end
      if (w_adv4) begin
        r_v4 <= r_v3;
        if (r_v3) begin
          r_diff <= w_d4;
          r_bout <= ~w_sum4[8];
          r_ovf  <= (r_a3[7] != r_b3[7])
                 && (w_d4[31] != r_a3[7]);
          r_zero <= (w_d4 == 32'd0);
        end
      end
    end
  end

  assign bus.in_ready  = w_adv1 && !rst;
  assign bus.out_valid = r_v4;
  assign bus.Diff      = r_diff;
  assign bus.Bout      = r_bout;
  assign bus.Ovf       = r_ovf;
  assign bus.Zero      = r_zero;
endmodule

// File: tb/tb_sub_pipe_32bit.sv
// Directed and scoreboard bench for sub_pipe_32bit.
module tb_sub_pipe_32bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sub_pipe_32bit_if bus();

  sub_pipe_32bit dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [34:0] exp_q[$];
  logic [34:0] sb_e;
  logic [34:0] sb_h;
  bit rand_bp = 1'b0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {Ovf, Zero, Bout, Diff} from a 33-bit reference subtraction
  function automatic logic [34:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic bin);
    logic [32:0] t;
    logic ov;
    logic z;
    t  = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    ov = (a[31] != b[31]) && (t[31] != a[31]);
    z  = (t[31:0] == 32'd0);
    return {ov, z, t[32], t[31:0]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          check("unexp_out", bus.out_valid, 0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb", {bus.Ovf, bus.Zero, bus.Bout, bus.Diff}, sb_e);
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.A, bus.B, bus.Bin));
    end
  end

  task automatic send(input logic [31:0] a,
                      input logic [31:0] b,
                      input logic bin,
                      output int waits);
    logic ok;
    bus.A        = a;
    bus.B        = b;
    bus.Bin      = bin;
    bus.in_valid = 1'b1;
    waits = 0;
    forever begin
      if (rand_bp) bus.out_ready = ($urandom_range(0, 1) == 1);
      #1;
      ok = bus.in_ready;
      @(negedge clk);
      if (ok) break;
      waits++;
      if (waits > 50) begin
        check("send_timeout", waits, 0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_one(input string tag,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic bin,
                         input logic [31:0] ed,
                         input logic eb,
                         input logic eo,
                         input logic ez);
    int w;
    int n;
    send(a, b, bin, w);
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, 4);
    check({tag, "_diff"}, bus.Diff, ed);
    check({tag, "_bout"}, bus.Bout, eb);
    check({tag, "_ovf"}, bus.Ovf, eo);
    check({tag, "_zero"}, bus.Zero, ez);
  endtask

  task automatic drain(input string tag);
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int p0;
    int seen;
    logic [31:0] ra;
    logic [31:0] rb;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Bin       = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_ready", bus.in_ready, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_diff", bus.Diff, 0);
    check("rst_flags", {bus.Bout, bus.Ovf, bus.Zero}, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", bus.in_ready, 1);

    run_one("basic", 32'd5, 32'd3, 1'b0,
            32'h0000_0002, 1'b0, 1'b0, 1'b0);
    run_one("wrap", 32'd0, 32'd1, 1'b0,
            32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_one("eq_bin", 32'h1234_5678, 32'h1234_5678, 1'b1,
            32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_one("eq", 32'h1234_5678, 32'h1234_5678, 1'b0,
            32'h0000_0000, 1'b0, 1'b0, 1'b1);
    run_one("ovf_neg", 32'h8000_0000, 32'd1, 1'b0,
            32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_one("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0,
            32'h8000_0000, 1'b1, 1'b1, 1'b0);

    // backpressure: four fill the pipe, the rest follow on release
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'h0100_0000 * (i + 1) + 32'h0000_00FF,
           32'h0000_0100 * (i + 3), 1'(i & 1), w);
      check("bp_fill_wait", w, 0);
    end
    #1;
    check("bp_full_ready", bus.in_ready, 0);
    check("bp_full_valid", bus.out_valid, 1);
    check("bp_qsize", exp_q.size(), 4);
    sb_h = exp_q[0];
    check("bp_head", bus.Diff, sb_h[31:0]);
    repeat (3) @(negedge clk);
    check("bp_hold_diff", bus.Diff, sb_h[31:0]);
    check("bp_hold_bout", bus.Bout, sb_h[32]);
    check("bp_hold_valid", bus.out_valid, 1);
    p0 = pops;
    bus.out_ready = 1'b1;
    for (int i = 4; i < 8; i++) begin
      send(32'hFFFF_0000 - i, 32'hFFFF_0000 + i, 1'(i & 1), w);
      check("bp_flow_wait", w, 0);
    end
    drain("bp");
    check("bp_count", pops - p0, 8);

    // alternate-cycle pulses must pack without holes
    bus.out_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      send(32'h0000_1000 + i, 32'h0000_2000, 1'b0, w);
      check("bub_wait", w, 0);
      if (i < 3) @(negedge clk);
    end
    #1;
    check("bub_full_ready", bus.in_ready, 0);
    check("bub_qsize", exp_q.size(), 4);
    drain("bub");
    check("bub_count", pops - p0, 4);

    // reset with operands in flight
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      send(32'hDEAD_0000 + i, 32'h0000_BEEF, 1'b1, w);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_diff", bus.Diff, 0);
    check("mid_rst_flags", {bus.Bout, bus.Ovf, bus.Zero}, 0);
    check("mid_rst_ready", bus.in_ready, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("mid_rst_stale", seen, 0);

    rand_bp = 1'b1;
    p0 = pops;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 0) rb = ra;
      send(ra, rb, 1'($urandom_range(0, 1)), w);
    end
    rand_bp = 1'b0;
    drain("rnd");
    check("rnd_count", pops - p0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
